// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises IF fetches and MEM loads/stores onto one
// variable-latency memory, returning read data and per-stage stall signals.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_t;

  state_t           state, state_nx;
  logic             owner_dm;
  logic             last_dm;
  logic             flushed;
  logic             to_flag;
  logic [CNT_W-1:0] cnt;
  logic             in_acc;
  logic             timeout_hit;
  logic             req_if_m, req_dm_m;
  logic             grant_if, grant_dm;

  assign in_acc      = (state == IF_ACC) || (state == DM_ACC);
  assign timeout_hit = TO_EN && in_acc && !mem_ack && (cnt == CNT_LAST);

  // In DONE the owner's request is still high for the access being acked, so it is masked.
  always_comb begin
    req_if_m = if_req;
    req_dm_m = dm_req;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    state_nx = state;
    if (state == DONE) begin
      if (owner_dm) req_dm_m = 1'b0;
      else          req_if_m = 1'b0;
    end
    if (start && ((state == IDLE) || (state == DONE))) begin
      if (req_if_m && req_dm_m) begin
        grant_dm = !last_dm;
        grant_if = last_dm;
      end else begin
        grant_if = req_if_m;
        grant_dm = req_dm_m;
      end
    end
    case (state)
      IDLE, DONE: begin
        if (grant_dm)      state_nx = DM_ACC;
        else if (grant_if) state_nx = IF_ACC;
        else               state_nx = IDLE;
      end
      IF_ACC, DM_ACC: begin
        if (mem_ack || timeout_hit) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign if_ack   = (state == DONE) && !owner_dm && !flushed;
  assign dm_ack   = (state == DONE) && owner_dm;
  assign err      = (if_ack || dm_ack) && to_flag;
  assign busy     = (state != IDLE);
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      last_dm   <= 1'b0;
      flushed   <= 1'b0;
      to_flag   <= 1'b0;
      cnt       <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (in_acc) begin
        cnt <= cnt + 1'b1;
        // A fetch withdrawn mid-access (branch flush) still finishes at memory, unacked.
        if ((state == IF_ACC) && !if_req) flushed <= 1'b1;
        if (mem_ack) begin
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          if (state == IF_ACC) if_rdata <= mem_rdata;
          else if (!mem_we)    dm_rdata <= mem_rdata;
        end else if (timeout_hit) begin
          mem_cs  <= 1'b0;
          mem_we  <= 1'b0;
          to_flag <= 1'b1;
        end
      end
      if (state == DONE) begin
        last_dm <= owner_dm;
        cnt     <= '0;
        to_flag <= 1'b0;
        flushed <= 1'b0;
      end
      if (grant_if || grant_dm) begin
        mem_cs   <= 1'b1;
        owner_dm <= grant_dm;
        mem_addr <= grant_dm ? dm_addr : if_addr;
        mem_we   <= grant_dm & dm_we;
        if (grant_dm) mem_wdata <= dm_wdata;
        cnt     <= '0;
        to_flag <= 1'b0;
        flushed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vector table, directed corner sequences, and
// randomized traffic scored against a transaction-level memory/arbitration model.
module tb_mem_arbiter;

  logic        clk, rst, start;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_ack, if_stall;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack, dm_stall;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, err, busy;

  int n_chk = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic        start, if_req, dm_req, dm_we, mem_ack;
    logic [31:0] rd_in;
    logic [7:0]  exp;       // {mem_cs, mem_we, if_ack, dm_ack, err, busy, if_stall, dm_stall}
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  // Memory device contents and the requesters' own view of what memory should hold.
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, ir, dr, we, ack, input logic [31:0] rd,
                     input logic [7:0] e, input logic [31:0] ea, input logic [31:0] erd);
    vec_t v;
    v.start = st; v.if_req = ir; v.dm_req = dr; v.dm_we = we; v.mem_ack = ack;
    v.rd_in = rd; v.exp = e; v.exp_addr = ea; v.exp_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic dm_xact(input logic we, input logic [31:0] addr, wd, rdv, input int lat,
                         output int cs_n, output logic e, output logic [31:0] rd, output logic ok);
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    cs_n = 0; ok = 1'b0; e = 1'b0; rd = '0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      mem_ack = 1'b0;
      if (mem_cs) begin
        cs_n++;
        if (cs_n == lat) begin mem_ack = 1'b1; mem_rdata = rdv; end
      end
      #1;
      if (dm_ack) begin ok = 1'b1; e = err; rd = dm_rdata; end
    end
    mem_ack = 1'b0;
    step();
    dm_req = 1'b0;
  endtask

  // Random traffic; when alt is set both stages re-request at once and grants must alternate.
  task automatic run_traffic(input int n_acks, input int pct, input int lmin, input int lmax,
                             input bit alt, input int stall_max);
    int acks = 0, cyc_n = 0, if_wait = 0, dm_wait = 0, cs_n = 0, lat = 1;
    bit if_done = 0, dm_done = 0, prev_dm = 0;
    logic [31:0] sl_addr = '0, sl_wdata = '0;
    logic sl_we = 1'b0;
    start = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    while (acks < n_acks && cyc_n < 3000) begin
      step();
      cyc_n++;
      if (if_done) begin if_req = 1'b0; if_done = 0; end
      if (dm_done) begin dm_req = 1'b0; dm_done = 0; end
      if (!if_req && $urandom_range(99) < pct) begin
        if_req = 1'b1; if_addr = 32'h1000 + ($urandom_range(63) << 2);
      end
      if (!dm_req && $urandom_range(99) < pct) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(1));
        dm_addr = 32'h2000 + ($urandom_range(7) << 2); dm_wdata = $urandom;
      end
      mem_ack = 1'b0;
      if (mem_cs) begin
        if (cs_n == 0) lat = $urandom_range(lmax, lmin);
        cs_n++;
        if (cs_n == lat) begin
          mem_ack = 1'b1; sl_addr = mem_addr; sl_we = mem_we; sl_wdata = mem_wdata;
          if (mem_we) dev_mem[mem_addr] = mem_wdata;
          else        mem_rdata = dev_rd(mem_addr);
        end
      end else cs_n = 0;
      #1;
      chk("if_stall", if_stall, if_req & ~if_ack);
      chk("dm_stall", dm_stall, dm_req & ~dm_ack);
      if (if_ack) begin
        if_done = 1;
        chk("if_data", if_rdata, init_val(if_addr));
        chk("if_cmd", {sl_addr, 31'd0, sl_we}, {if_addr, 32'd0});
        chk("if_err", err, 1'b0);
        if (alt) chk("alt_order_if", prev_dm, (acks == 0) ? 1'b0 : 1'b1);
        prev_dm = 0; acks++;
      end
      if (dm_ack) begin
        dm_done = 1;
        chk("dm_cmd", {sl_addr, 31'd0, sl_we}, {dm_addr, 31'd0, dm_we});
        if (dm_we) begin
          chk("dm_wdata", sl_wdata, dm_wdata);
          ref_mem[dm_addr] = dm_wdata;
        end else chk("dm_data", dm_rdata, ref_rd(dm_addr));
        chk("dm_err", err, 1'b0);
        if (alt) chk("alt_order_dm", prev_dm, (acks == 0) ? 1'b0 : 1'b0);
        if (alt && acks == 0) chk("alt_first_dm", 1'b1, 1'b1 & dm_ack);
        prev_dm = 1; acks++;
      end
      if (if_stall) if_wait++; else if_wait = 0;
      if (dm_stall) dm_wait++; else dm_wait = 0;
      if (if_wait > stall_max) begin chk("if_stall_len", if_wait, stall_max); if_wait = 0; end
      if (dm_wait > stall_max) begin chk("dm_stall_len", dm_wait, stall_max); dm_wait = 0; end
    end
    chk("traffic_acks", acks, n_acks);
    step();
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  int          cs_n;
  logic        e_o, ok;
  logic [31:0] rd_o;
  vec_t        v;

  initial begin
    rst = 1'b1; start = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    #1;
    chk("reset_ctl", {mem_cs, mem_we, if_ack, dm_ack, err, busy}, 6'b0);
    chk("reset_data", {if_rdata, dm_rdata}, 64'd0);
    chk("reset_mem", {mem_addr, mem_wdata}, 64'd0);

    // Single fetch, DM-first tie, start gating, start falling mid-access.
    add(1,1,0,0,0, 32'h0,        8'b0000_0010, 32'h0,   32'h0);
    add(1,1,0,0,0, 32'h0,        8'b1000_0110, 32'h40,  32'h0);
    add(1,1,0,0,0, 32'h0,        8'b1000_0110, 32'h40,  32'h0);
    add(1,1,0,0,1, 32'h8C220004, 8'b1000_0110, 32'h40,  32'h0);
    add(1,1,0,0,0, 32'h0,        8'b0010_0100, 32'h0,   32'h8C220004);
    add(1,0,0,0,0, 32'h0,        8'b0000_0000, 32'h0,   32'h0);
    add(1,1,1,1,0, 32'h0,        8'b0000_0011, 32'h0,   32'h0);
    add(1,1,1,1,1, 32'h0,        8'b1100_0111, 32'h100, 32'h0);
    add(1,1,1,1,0, 32'h0,        8'b0001_0110, 32'h0,   32'h0);
    add(1,1,0,1,1, 32'h11111111, 8'b1000_0110, 32'h40,  32'h0);
    add(1,1,0,0,0, 32'h0,        8'b0010_0100, 32'h0,   32'h11111111);
    add(1,0,0,0,0, 32'h0,        8'b0000_0000, 32'h0,   32'h0);
    add(0,1,0,0,0, 32'h0,        8'b0000_0010, 32'h0,   32'h0);
    add(0,1,0,0,0, 32'h0,        8'b0000_0010, 32'h0,   32'h0);
    add(1,1,0,0,0, 32'h0,        8'b0000_0010, 32'h0,   32'h0);
    add(1,1,0,0,1, 32'h22222222, 8'b1000_0110, 32'h40,  32'h0);
    add(1,1,0,0,0, 32'h0,        8'b0010_0100, 32'h0,   32'h22222222);
    add(1,0,0,0,0, 32'h0,        8'b0000_0000, 32'h0,   32'h0);
    add(1,1,1,0,0, 32'h0,        8'b0000_0011, 32'h0,   32'h0);
    add(0,1,1,0,0, 32'h0,        8'b1000_0111, 32'h100, 32'h0);
    add(0,1,1,0,1, 32'h33333333, 8'b1000_0111, 32'h100, 32'h0);
    add(0,1,1,0,0, 32'h0,        8'b0001_0110, 32'h0,   32'h33333333);
    add(0,1,0,0,0, 32'h0,        8'b0000_0010, 32'h0,   32'h0);
    add(0,1,0,0,0, 32'h0,        8'b0000_0010, 32'h0,   32'h0);
    add(1,0,0,0,0, 32'h0,        8'b0000_0000, 32'h0,   32'h0);

    rst = 1'b0;
    if_addr = 32'h40; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      start = v.start; if_req = v.if_req; dm_req = v.dm_req; dm_we = v.dm_we;
      mem_ack = v.mem_ack; mem_rdata = v.rd_in;
      #1;
      chk($sformatf("vec%0d_ctl", i),
          {mem_cs, mem_we, if_ack, dm_ack, err, busy, if_stall, dm_stall}, v.exp);
      if (v.exp[7]) chk($sformatf("vec%0d_addr", i), mem_addr, v.exp_addr);
      if (v.exp[6]) chk($sformatf("vec%0d_wdata", i), mem_wdata, 32'hDEADBEEF);
      if (v.exp[5]) chk($sformatf("vec%0d_if_rdata", i), if_rdata, v.exp_rd);
      if (v.exp[4] && !v.dm_we) chk($sformatf("vec%0d_dm_rdata", i), dm_rdata, v.exp_rd);
      step();
    end

    // Timeout: a good read, a read memory never acks, then a normal write.
    start = 1'b1; if_req = 1'b0;
    dm_xact(1'b0, 32'h300, 32'h0, 32'h12345678, 1, cs_n, e_o, rd_o, ok);
    chk("rd_ok", {ok, e_o, rd_o}, {1'b1, 1'b0, 32'h12345678});
    dm_xact(1'b0, 32'h304, 32'h0, 32'hFFFFFFFF, 0, cs_n, e_o, rd_o, ok);
    chk("to_ack", ok, 1'b1);
    chk("to_cs_cycles", cs_n, 4);
    chk("to_err", e_o, 1'b1);
    chk("to_rdata_held", rd_o, 32'h12345678);
    dm_xact(1'b1, 32'h308, 32'hCAFEF00D, 32'h0, 2, cs_n, e_o, rd_o, ok);
    chk("after_to", {ok, e_o, cs_n[3:0]}, {1'b1, 1'b0, 4'd2});

    // Flush: fetch withdrawn mid-access completes at memory without if_ack.
    if_req = 1'b1; if_addr = 32'h80;
    step();
    #1; chk("flush_cs", {mem_cs, mem_addr}, {1'b1, 32'h80});
    if_req = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h44444444;
    #1; chk("flush_cs_held", mem_cs, 1'b1);
    step();
    mem_ack = 1'b0;
    #1; chk("flush_done", {if_ack, err, mem_cs, busy}, 4'b0001);
    step();
    #1; chk("flush_idle", {if_ack, busy}, 2'b00);

    // Reset during the second cycle of a fetch, then re-grant of the held request.
    if_req = 1'b1; if_addr = 32'h88;
    step();
    step();
    #1; chk("rst_acc", {mem_cs, busy}, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1; chk("rst_abandon", {mem_cs, if_ack, busy, mem_addr}, {3'b000, 32'h0});
    step();
    #1; chk("rst_regrant", {mem_cs, mem_addr}, {1'b1, 32'h88});
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 1'b0;
    #1; chk("rst_ack", {if_ack, if_rdata}, {1'b1, 32'h55555555});
    step();
    if_req = 1'b0;
    step();

    // Sustained contention from reset: 8 accesses alternating DM, IF.
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_traffic(8, 100, 2, 2, 1'b1, 6);

    run_traffic(60, 40, 1, 4, 1'b0, 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
